// File: rtl/sq_retire_wbuf.sv
// Retired-store write buffer: circular FIFO drained to memory by an IDLE/WRITE FSM.
// Optional same-word store merging is enabled by defining SQ_RETIRE_WBUF_COALESCE_EN.
module sq_retire_wbuf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_sq_retire_en,
  input  logic [DATA_WIDTH/8-1:0] i_sq_retire_byte_en,
  input  logic [ADDR_WIDTH-1:0]   i_sq_retire_addr,
  input  logic [DATA_WIDTH-1:0]   i_sq_retire_data,
  output logic                    o_sq_retire_dc_hit,
  output logic                    o_sq_retire_msq_full,
  output logic                    o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_byte_en,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  input  logic                    i_mem_wr_ack,
  output logic                    o_empty
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [BW-1:0]         ent_be   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          hit_q, full_q;

  logic [ADDR_WIDTH-1:0] req_waddr;
  logic                  push, pop, merge;

  assign req_waddr = (i_sq_retire_addr >> OFF) << OFF;

`ifdef SQ_RETIRE_WBUF_COALESCE_EN
  logic [PW-1:0] merge_idx;

  // Oldest-to-youngest scan so the youngest match wins; a head being written is off limits.
  always_comb begin
    merge     = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q &&
          !(i == 0 && state_q == WRITE) &&
          ent_addr[head_q + PW'(i)] == req_waddr) begin
        merge     = i_sq_retire_en;
        merge_idx = head_q + PW'(i);
      end
    end
  end
`else
  assign merge = 1'b0;
`endif

  assign push = i_sq_retire_en && !merge && (count_q < CW'(DEPTH));
  assign pop  = (state_q == WRITE) && i_mem_wr_ack;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = WRITE;
      WRITE:   if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hit_q   <= i_sq_retire_en && (push || merge);
      full_q  <= i_sq_retire_en && !push && !merge;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Entry storage carries no reset; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail_q] <= req_waddr;
      ent_be[tail_q]   <= i_sq_retire_byte_en;
      ent_data[tail_q] <= i_sq_retire_data;
    end
`ifdef SQ_RETIRE_WBUF_COALESCE_EN
    else if (merge) begin
      ent_be[merge_idx] <= ent_be[merge_idx] | i_sq_retire_byte_en;
      for (int b = 0; b < BW; b++) begin
        if (i_sq_retire_byte_en[b]) begin
          ent_data[merge_idx][b*8 +: 8] <= i_sq_retire_data[b*8 +: 8];
        end
      end
    end
`endif
  end

  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = '0;
    o_mem_byte_en = '0;
    o_mem_data    = '0;
    if (state_q == WRITE) begin
      o_mem_wr_en   = 1'b1;
      o_mem_addr    = ent_addr[head_q];
      o_mem_byte_en = ent_be[head_q];
      o_mem_data    = ent_data[head_q];
    end
  end

  assign o_sq_retire_dc_hit   = hit_q;
  assign o_sq_retire_msq_full = full_q;
  assign o_empty              = (count_q == '0) && (state_q == IDLE);

endmodule
